// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the multi-cycle RV32I core.
//   - OP_* opcode constants (IR[6:0])
//   - alu_op_e: ALU operation encoding driven on alu_ctrl_o
//   - ctrl_state_e: main control FSM states
//   - RES_*, SRCA_*, SRCB_*: datapath mux select encodings
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJalr     = 4'd10,
        StJal      = 4'd11,
        StLui      = 4'd12,
        StTrap     = 4'd13
    } ctrl_state_e;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_a encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU decoder for OP and OP-IMM instructions.
// Ports:
//   funct3_i    in  3  IR[14:12]
//   funct7b5_i  in  1  IR[30]
//   is_rtype_i  in  1  1 = register-register (OP), 0 = immediate (OP-IMM)
//   alu_op_o    out    selected ALU operation
module alu_dec
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output alu_op_e    alu_op_o
);

    always_comb begin
        alu_op_o = AluAdd;
        unique case (funct3_i)
            // IR[30] is part of the immediate for addi, so only R-type may pick SUB
            3'b000:  alu_op_o = (is_rtype_i && funct7b5_i) ? AluSub : AluAdd;
            3'b001:  alu_op_o = AluSll;
            3'b010:  alu_op_o = AluSlt;
            3'b011:  alu_op_o = AluSltu;
            3'b100:  alu_op_o = AluXor;
            3'b101:  alu_op_o = funct7b5_i ? AluSra : AluSrl;
            3'b110:  alu_op_o = AluOr;
            3'b111:  alu_op_o = AluAnd;
            default: alu_op_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences the shared ALU, the single memory port, IR/oldPC and ALUOut.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   op_i, funct3_i, funct7b5_i      instruction fields from IR
//   branch_taken_i                  compare-unit result, used in BRANCH
//   mem_ready_i                     memory completes the current request
//   mem_req_o, mem_we_o, adr_src_o  memory request, write, address source
//   ir_write_o, pc_write_o          IR/oldPC load, PC load
//   reg_write_o                     register-file write enable
//   result_src_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o   datapath control
//   retire_o                        one-cycle pulse per completed instruction
//   illegal_o                       illegal-opcode trap flag
// Optional feature: define CTRL_TRAP_ILLEGAL_EN to trap unknown opcodes in TRAP;
// otherwise they retire as a NOP and illegal_o is tied to 0.
// Outputs are combinational from the state and inputs.
module multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT_EN_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [3:0] alu_ctrl_o,
    output logic       retire_o,
    output logic       illegal_o
);

    if (MEM_TIMEOUT_EN_CYCLES != 0) begin : g_timeout_unsupported
        $error("multicycle_ctrl: MEM_TIMEOUT_EN_CYCLES is reserved and must be 0");
    end

    ctrl_state_e state_q, state_d;
    alu_op_e     dec_op;

    alu_dec u_alu_dec (
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .is_rtype_i (state_q == StExecR),
        .alu_op_o   (dec_op)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        alu_ctrl_o   = AluAdd;
        retire_o     = 1'b0;
        illegal_o    = 1'b0;
        // Outputs stay at defaults while reset is held, so memory never sees a
        // fetch request (or IR/PC writes) before reset is released.
        if (rst_ni) begin
            case (state_q)
                StFetch: begin
                    mem_req_o    = 1'b1;
                    alu_src_a_o  = SRCA_PC;
                    alu_src_b_o  = SRCB_FOUR;
                    result_src_o = RES_ALU;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = StDecode;
                    end
                end
                StDecode: begin
                    // ALUOut <- oldPC + imm: branch/JAL target, AUIPC result
                    alu_src_a_o = SRCA_OLDPC;
                    alu_src_b_o = SRCB_IMM;
                    case (op_i)
                        OP_LOAD, OP_STORE: state_d = StMemAdr;
                        OP_OP:             state_d = StExecR;
                        OP_ALUI:           state_d = StExecI;
                        OP_BRANCH:         state_d = StBranch;
                        OP_JAL:            state_d = StJal;
                        OP_JALR:           state_d = StJalr;
                        OP_LUI:            state_d = StLui;
                        OP_AUIPC:          state_d = StAluWb;
                        default: begin
`ifdef CTRL_TRAP_ILLEGAL_EN
                            state_d = StTrap;
`else
                            retire_o = 1'b1;
                            state_d  = StFetch;
`endif
                        end
                    endcase
                end
                StMemAdr: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                    state_d     = (op_i == OP_STORE) ? StMemWrite : StMemRead;
                end
                StMemRead: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                    if (mem_ready_i) begin
                        state_d = StMemWb;
                    end
                end
                StMemWb: begin
                    result_src_o = RES_RDATA;
                    reg_write_o  = 1'b1;
                    retire_o     = 1'b1;
                    state_d      = StFetch;
                end
                StMemWrite: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    adr_src_o = 1'b1;
                    if (mem_ready_i) begin
                        retire_o = 1'b1;
                        state_d  = StFetch;
                    end
                end
                StExecR: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_RS2;
                    alu_ctrl_o  = dec_op;
                    state_d     = StAluWb;
                end
                StExecI: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                    alu_ctrl_o  = dec_op;
                    state_d     = StAluWb;
                end
                StAluWb: begin
                    result_src_o = RES_ALUOUT;
                    reg_write_o  = 1'b1;
                    retire_o     = 1'b1;
                    state_d      = StFetch;
                end
                StBranch: begin
                    // ALU compares; PC takes the target computed into ALUOut in DECODE
                    alu_src_a_o  = SRCA_RS1;
                    alu_src_b_o  = SRCB_RS2;
                    alu_ctrl_o   = AluSub;
                    result_src_o = RES_ALUOUT;
                    pc_write_o   = branch_taken_i;
                    retire_o     = 1'b1;
                    state_d      = StFetch;
                end
                StJalr: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                    state_d     = StJal;
                end
                StJal: begin
                    // PC <- ALUOut (target) while the ALU forms oldPC + 4 for rd
                    alu_src_a_o  = SRCA_OLDPC;
                    alu_src_b_o  = SRCB_FOUR;
                    result_src_o = RES_ALUOUT;
                    pc_write_o   = 1'b1;
                    state_d      = StAluWb;
                end
                StLui: begin
                    alu_src_a_o = SRCA_ZERO;
                    alu_src_b_o = SRCB_IMM;
                    state_d     = StAluWb;
                end
                StTrap: begin
`ifdef CTRL_TRAP_ILLEGAL_EN
                    illegal_o = 1'b1;
                    state_d   = StTrap;
`else
                    state_d   = StFetch;
`endif
                end
                default: state_d = StFetch;
            endcase
        end
    end

endmodule
